// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: functional-unit codes,
// default queue depth and the round-robin grant helper.
package wb_pkg;

    localparam int WB_DEPTH = 2;
    localparam int REG_W    = 5;

    typedef enum logic [1:0] {
        UNIT_AM   = 2'b00,
        UNIT_MEM  = 2'b01,
        UNIT_MUL  = 2'b10,
        UNIT_NONE = 2'b11
    } unit_e;

    // First requesting unit in AM->MEM->MUL order, starting after the last grant.
    function automatic unit_e rr_pick(input unit_e last, input logic [2:0] req);
        unit_e first_u;
        unit_e second_u;
        unit_e third_u;
        unit_e pick;
        case (last)
            UNIT_AM: begin
                first_u  = UNIT_MEM;
                second_u = UNIT_MUL;
                third_u  = UNIT_AM;
            end
            UNIT_MEM: begin
                first_u  = UNIT_MUL;
                second_u = UNIT_AM;
                third_u  = UNIT_MEM;
            end
            default: begin
                first_u  = UNIT_AM;
                second_u = UNIT_MEM;
                third_u  = UNIT_MUL;
            end
        endcase
        if (req[first_u]) begin
            pick = first_u;
        end else if (req[second_u]) begin
            pick = second_u;
        end else if (req[third_u]) begin
            pick = third_u;
        end else begin
            pick = UNIT_NONE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_queue.sv
// Small FIFO holding completed results of one functional unit.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int W     = 37,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next storage, pointer and occupancy state.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: rtl/writeback_arbiter.sv
// Collects AluMisc/Mem/Mult results into per-unit queues and issues one
// register-file write plus scoreboard release per cycle, round-robin.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              am_wb_valid,
    input  logic [REG_W-1:0]  am_wb_regdest,
    input  logic              am_wb_writereg,
    input  logic [DATA_W-1:0] am_wb_data,
    output logic              am_wb_ready,
    input  logic              mem_wb_valid,
    input  logic [REG_W-1:0]  mem_wb_regdest,
    input  logic              mem_wb_writereg,
    input  logic [DATA_W-1:0] mem_wb_data,
    output logic              mem_wb_ready,
    input  logic              mul_wb_valid,
    input  logic [REG_W-1:0]  mul_wb_regdest,
    input  logic              mul_wb_writereg,
    input  logic [DATA_W-1:0] mul_wb_data,
    output logic              mul_wb_ready,
    output logic [REG_W-1:0]  wb_reg_writeaddr,
    output logic [DATA_W-1:0] wb_reg_writedata,
    output logic              wb_reg_writeenable,
    output logic [REG_W-1:0]  wb_sb_writeaddr,
    output logic [1:0]        wb_sb_registerunit,
    output logic              wb_sb_enablewrite
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = REG_W + DATA_W;

    logic [2:0]        valid_s, writereg_s, push_s, pop_s, full_s, empty_s;
    logic [REG_W-1:0]  regdest_s [3];
    logic [DATA_W-1:0] data_s    [3];
    logic [ENT_W-1:0]  head_s    [3];
    logic [CNT_W-1:0]  count_s   [3];
    logic [ENT_W-1:0]  grant_head_s;
    unit_e             grant_s;

    unit_e             last_q, last_d;
    logic              strobe_q, strobe_d;
    logic [REG_W-1:0]  waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        unit_q, unit_d;

    assign valid_s      = {mul_wb_valid, mem_wb_valid, am_wb_valid};
    assign writereg_s   = {mul_wb_writereg, mem_wb_writereg, am_wb_writereg};
    assign regdest_s[0] = am_wb_regdest;
    assign regdest_s[1] = mem_wb_regdest;
    assign regdest_s[2] = mul_wb_regdest;
    assign data_s[0]    = am_wb_data;
    assign data_s[1]    = mem_wb_data;
    assign data_s[2]    = mul_wb_data;

    assign am_wb_ready  = (count_s[0] < CNT_W'(DEPTH));
    assign mem_wb_ready = (count_s[1] < CNT_W'(DEPTH));
    assign mul_wb_ready = (count_s[2] < CNT_W'(DEPTH));

    // Stores and writes to r0 are consumed by the handshake but never queued.
    always_comb begin
        push_s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            push_s[i] = valid_s[i] & ~full_s[i] & writereg_s[i] & (regdest_s[i] != '0);
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_q
        wb_queue #(.DEPTH(DEPTH), .W(ENT_W), .CNT_W(CNT_W)) u_q (
            .clock     (clock),
            .reset     (reset),
            .push      (push_s[g]),
            .push_data ({regdest_s[g], data_s[g]}),
            .pop       (pop_s[g]),
            .head_data (head_s[g]),
            .count     (count_s[g]),
            .full      (full_s[g]),
            .empty     (empty_s[g])
        );
    end

    // Grant selection, head pop and next write-port values.
    always_comb begin
        grant_s      = rr_pick(last_q, ~empty_s);
        pop_s        = 3'b000;
        grant_head_s = '0;
        last_d       = last_q;
        strobe_d     = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        unit_d       = unit_q;
        case (grant_s)
            UNIT_AM: begin
                pop_s        = 3'b001;
                grant_head_s = head_s[0];
            end
            UNIT_MEM: begin
                pop_s        = 3'b010;
                grant_head_s = head_s[1];
            end
            UNIT_MUL: begin
                pop_s        = 3'b100;
                grant_head_s = head_s[2];
            end
            default: begin
                pop_s        = 3'b000;
                grant_head_s = '0;
            end
        endcase
        if (grant_s != UNIT_NONE) begin
            last_d   = grant_s;
            strobe_d = 1'b1;
            waddr_d  = grant_head_s[ENT_W-1:DATA_W];
            wdata_d  = grant_head_s[DATA_W-1:0];
            unit_d   = grant_s;
        end else begin
            strobe_d = 1'b0;
        end
    end

    // Arbitration pointer and write-port registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_q   <= UNIT_AM;
            strobe_q <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            unit_q   <= 2'b00;
        end else begin
            last_q   <= last_d;
            strobe_q <= strobe_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            unit_q   <= unit_d;
        end
    end

    assign wb_reg_writeaddr   = waddr_q;
    assign wb_reg_writedata   = wdata_q;
    assign wb_reg_writeenable = strobe_q;
    assign wb_sb_writeaddr    = waddr_q;
    assign wb_sb_registerunit = unit_q;
    assign wb_sb_enablewrite  = strobe_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomised and directed bench for writeback_arbiter with a queue-based
// reference model and a scoreboard monitor on the write port.
module tb_writeback_arbiter;
    import wb_pkg::*;

    localparam int DEPTH  = 2;
    localparam int DATA_W = 32;

    typedef struct packed { logic [4:0] rd; logic wr; logic [31:0] data; } item_t;
    typedef struct packed { logic [1:0] unit; logic [4:0] rd; logic [31:0] data; } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic        v   [3];
    logic [4:0]  rd  [3];
    logic        wr  [3];
    logic [31:0] dat [3];
    logic am_ready, mem_ready, mul_ready;
    logic [4:0]  reg_addr, sb_addr;
    logic [31:0] reg_data;
    logic        reg_we, sb_we;
    logic [1:0]  sb_unit;

    int n_tests = 0;
    int n_fail  = 0;

    item_t stim0[$], stim1[$], stim2[$];
    item_t mq0[$], mq1[$], mq2[$];
    wr_t   exp_q[$];
    wr_t   wlog[$];
    bit    acc [3];
    int    last_u = 0;
    bit    seen_mul_stall = 0;
    bit    win = 0;
    int    gcnt [3];
    int    idle_cnt = 0;

    always #5 clock = ~clock;

    writeback_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset),
        .am_wb_valid(v[0]), .am_wb_regdest(rd[0]), .am_wb_writereg(wr[0]), .am_wb_data(dat[0]), .am_wb_ready(am_ready),
        .mem_wb_valid(v[1]), .mem_wb_regdest(rd[1]), .mem_wb_writereg(wr[1]), .mem_wb_data(dat[1]), .mem_wb_ready(mem_ready),
        .mul_wb_valid(v[2]), .mul_wb_regdest(rd[2]), .mul_wb_writereg(wr[2]), .mul_wb_data(dat[2]), .mul_wb_ready(mul_ready),
        .wb_reg_writeaddr(reg_addr), .wb_reg_writedata(reg_data), .wb_reg_writeenable(reg_we),
        .wb_sb_writeaddr(sb_addr), .wb_sb_registerunit(sb_unit), .wb_sb_enablewrite(sb_we)
    );

    function automatic item_t mk(input int r, input bit w, input logic [31:0] d);
        item_t it;
        it.rd   = 5'(r);
        it.wr   = w;
        it.data = d;
        return it;
    endfunction

    function automatic int stim_size(input int u);
        case (u)
            0:       return stim0.size();
            1:       return stim1.size();
            default: return stim2.size();
        endcase
    endfunction

    function automatic void stim_push(input int u, input item_t it);
        case (u)
            0:       stim0.push_back(it);
            1:       stim1.push_back(it);
            default: stim2.push_back(it);
        endcase
    endfunction

    function automatic item_t stim_pop(input int u);
        case (u)
            0:       return stim0.pop_front();
            1:       return stim1.pop_front();
            default: return stim2.pop_front();
        endcase
    endfunction

    function automatic int mq_size(input int u);
        case (u)
            0:       return mq0.size();
            1:       return mq1.size();
            default: return mq2.size();
        endcase
    endfunction

    function automatic void mq_push(input int u, input item_t it);
        case (u)
            0:       mq0.push_back(it);
            1:       mq1.push_back(it);
            default: mq2.push_back(it);
        endcase
    endfunction

    function automatic item_t mq_pop(input int u);
        case (u)
            0:       return mq0.pop_front();
            1:       return mq1.pop_front();
            default: return mq2.pop_front();
        endcase
    endfunction

    function automatic logic dut_ready(input int u);
        case (u)
            0:       return am_ready;
            1:       return mem_ready;
            default: return mul_ready;
        endcase
    endfunction

    // Reference model: predicts readiness, acceptance and the next write.
    always @(negedge clock) begin
        int g;
        int cand;
        bit rdy_exp;
        item_t it;
        wr_t e;
        if (!reset) begin
            mq0.delete(); mq1.delete(); mq2.delete();
            exp_q.delete();
            last_u = 0;
            for (int u = 0; u < 3; u++) acc[u] = 1'b0;
        end else begin
            g = -1;
            for (int k = 1; k <= 3; k++) begin
                cand = (last_u + k) % 3;
                if (g < 0 && mq_size(cand) > 0) g = cand;
            end
            for (int u = 0; u < 3; u++) begin
                rdy_exp = (mq_size(u) < DEPTH);
                n_tests++;
                if (dut_ready(u) !== rdy_exp) begin
                    n_fail++;
                    $display("FAIL ready_u%0d: got %0b expected %0b", u, dut_ready(u), rdy_exp);
                end
                acc[u] = v[u] && rdy_exp;
                if (u == 2 && v[2] && !rdy_exp) seen_mul_stall = 1'b1;
            end
            if (g >= 0) begin
                it     = mq_pop(g);
                e.unit = 2'(g);
                e.rd   = it.rd;
                e.data = it.data;
                exp_q.push_back(e);
                last_u = g;
            end
            for (int u = 0; u < 3; u++) begin
                if (acc[u] && wr[u] && rd[u] != 5'd0) mq_push(u, mk(int'(rd[u]), 1'b1, dat[u]));
            end
        end
    end

    // Scoreboard monitor on the write port.
    always @(posedge clock) begin
        wr_t e;
        wr_t got;
        #1;
        n_tests++;
        if (reg_we !== sb_we || reg_addr !== sb_addr) begin
            n_fail++;
            $display("FAIL port_pair: reg we=%0b addr=%0d sb we=%0b addr=%0d, required identical", reg_we, reg_addr, sb_we, sb_addr);
        end
        n_tests++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (reg_we !== 1'b1 || reg_addr !== e.rd || reg_data !== e.data || sb_unit !== e.unit) begin
                n_fail++;
                $display("FAIL write: got we=%0b addr=%0d data=%h unit=%0d expected we=1 addr=%0d data=%h unit=%0d",
                         reg_we, reg_addr, reg_data, sb_unit, e.rd, e.data, e.unit);
            end
        end else if (reg_we !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_write: got we=%0b addr=%0d expected no write", reg_we, reg_addr);
        end
        if (reg_we === 1'b1) begin
            got.unit = sb_unit;
            got.rd   = reg_addr;
            got.data = reg_data;
            wlog.push_back(got);
        end
        if (win) begin
            if (reg_we === 1'b1 && sb_unit != 2'b11) gcnt[sb_unit]++;
            else idle_cnt++;
        end
    end

    task automatic tick();
        item_t it;
        @(posedge clock);
        #2;
        for (int u = 0; u < 3; u++) begin
            if (acc[u]) v[u] = 1'b0;
            if (!v[u] && stim_size(u) > 0) begin
                it     = stim_pop(u);
                v[u]   = 1'b1;
                rd[u]  = it.rd;
                wr[u]  = it.wr;
                dat[u] = it.data;
            end
        end
    endtask

    task automatic check(input bit ok, input string name, input int got, input int req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if (reg_we !== 1'b0 || sb_we !== 1'b0 || reg_addr !== 5'd0 || sb_addr !== 5'd0 ||
            reg_data !== 32'd0 || sb_unit !== 2'd0) begin
            n_fail++;
            $display("FAIL %s: we=%0b/%0b addr=%0d/%0d data=%h unit=%0d required all zero",
                     name, reg_we, sb_we, reg_addr, sb_addr, reg_data, sb_unit);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((stim0.size() + stim1.size() + stim2.size() + mq0.size() + mq1.size() + mq2.size()
                + exp_q.size()) != 0 || v[0] || v[1] || v[2]) begin
            tick();
            n++;
            if (n > 200) begin
                n_fail++;
                $display("FAIL drain_timeout: %0d cycles without emptying", n);
                break;
            end
        end
        tick();
    endtask

    initial begin
        int k;
        int mx;
        int mn;
        for (int u = 0; u < 3; u++) begin
            v[u] = 1'b0; rd[u] = 5'd0; wr[u] = 1'b0; dat[u] = 32'd0; gcnt[u] = 0;
        end
        repeat (3) @(posedge clock);
        #2;
        check_zero("reset_outputs");
        check(am_ready && mem_ready && mul_ready, "reset_ready", int'({am_ready, mem_ready, mul_ready}), 7);
        reset = 1'b1;
        tick(); tick();

        // Single AM result: write appears one edge after acceptance.
        stim_push(0, mk(5, 1'b1, 32'hDEADBEEF));
        tick();
        tick();
        tick();
        check(reg_we === 1'b1 && reg_addr == 5'd5 && sb_addr == 5'd5, "single_am_addr", int'(reg_addr), 5);
        check(reg_data == 32'hDEADBEEF, "single_am_data", int'(reg_data), 32'hDEADBEEF);
        check(sb_unit == 2'b00 && sb_we === 1'b1, "single_am_unit", int'(sb_unit), 0);
        tick();
        check(reg_we === 1'b0 && sb_we === 1'b0, "single_am_one_cycle", int'(reg_we), 0);

        // Leave the pointer on MUL, then three simultaneous results.
        stim_push(2, mk(7, 1'b1, 32'h1234_5678));
        drain();
        wlog.delete();
        stim_push(0, mk(1, 1'b1, 32'hA1));
        stim_push(1, mk(2, 1'b1, 32'hB2));
        stim_push(2, mk(3, 1'b1, 32'hC3));
        tick();
        @(negedge clock);
        #1;
        check(acc[0] && acc[1] && acc[2], "three_accept", int'({acc[2], acc[1], acc[0]}), 7);
        drain();
        check(wlog.size() == 3, "three_count", wlog.size(), 3);
        for (int i = 0; i < wlog.size() && i < 3; i++) begin
            check(wlog[i].rd == 5'(i + 1) && wlog[i].unit == 2'(i), "three_order", int'(wlog[i].rd), i + 1);
        end

        // Store and r0 write are consumed without any write.
        wlog.delete();
        stim_push(1, mk(9, 1'b0, 32'h55));
        stim_push(0, mk(0, 1'b1, 32'h66));
        repeat (6) tick();
        check(wlog.size() == 0, "filtered_no_write", wlog.size(), 0);
        check(!v[0] && !v[1], "filtered_accepted", int'({v[1], v[0]}), 0);

        // MUL overfills its queue while AM and MEM stay busy.
        wlog.delete();
        seen_mul_stall = 1'b0;
        for (int i = 0; i < 12; i++) begin
            stim_push(0, mk($urandom_range(1, 31), 1'b1, $urandom));
            stim_push(1, mk($urandom_range(1, 31), 1'b1, $urandom));
        end
        for (int i = 0; i < DEPTH + 1; i++) stim_push(2, mk(20 + i, 1'b1, 32'h7000 + i));
        drain();
        check(seen_mul_stall, "mul_stall_seen", int'(seen_mul_stall), 1);
        k = 0;
        foreach (wlog[i]) begin
            if (wlog[i].unit == 2'b10) begin
                check(wlog[i].rd == 5'(20 + k), "mul_order", int'(wlog[i].rd), 20 + k);
                k++;
            end
        end
        check(k == DEPTH + 1, "mul_count", k, DEPTH + 1);

        // Continuous traffic: fairness and full throughput.
        for (int i = 0; i < 400; i++) begin
            for (int u = 0; u < 3; u++) stim_push(u, mk($urandom_range(1, 31), 1'b1, $urandom));
        end
        repeat (10) tick();
        for (int u = 0; u < 3; u++) gcnt[u] = 0;
        idle_cnt = 0;
        win = 1'b1;
        repeat (300) tick();
        win = 1'b0;
        check(idle_cnt == 0, "throughput_idle", idle_cnt, 0);
        mx = gcnt[0]; mn = gcnt[0];
        for (int u = 1; u < 3; u++) begin
            if (gcnt[u] > mx) mx = gcnt[u];
            if (gcnt[u] < mn) mn = gcnt[u];
        end
        check(mx - mn <= 1, "fairness", mx - mn, 1);
        stim0.delete(); stim1.delete(); stim2.delete();
        drain();

        // Reset in the middle of a busy stream.
        for (int i = 0; i < 6; i++) begin
            for (int u = 0; u < 3; u++) stim_push(u, mk($urandom_range(1, 31), 1'b1, $urandom));
        end
        repeat (4) tick();
        check(mq0.size() == 2, "am_primed", mq0.size(), 2);
        reset = 1'b0;
        stim0.delete(); stim1.delete(); stim2.delete();
        for (int u = 0; u < 3; u++) v[u] = 1'b0;
        #1;
        check_zero("midstream_reset");
        wlog.delete();
        tick(); tick();
        reset = 1'b1;
        repeat (6) tick();
        check(wlog.size() == 0, "no_stale_write", wlog.size(), 0);

        // Random mix including stores and r0 destinations.
        for (int c = 0; c < 500; c++) begin
            for (int u = 0; u < 3; u++) begin
                if ($urandom_range(0, 1) == 1 && stim_size(u) < 2)
                    stim_push(u, mk($urandom_range(0, 31), ($urandom_range(0, 7) != 0), $urandom));
            end
            tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
Completion-side counterpart of the issue stage. It collects results from the three functional units (AluMisc, Mem, Mult) into per-unit queues and arbitrates one architectural register file write per cycle. For each write it drives the scoreboard write port, releasing the pending destination that issue reserved. It sits between the functional-unit outputs and the ARF/Scoreboard write interfaces.

Parameters:
DEPTH, 2, entries per unit queue; power of two, minimum 2
DATA_W, 32, result width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
am_wb_valid  in  1  AluMisc result valid
am_wb_regdest  in  5  AluMisc destination register
am_wb_writereg  in  1  AluMisc result writes a register
am_wb_data  in  DATA_W  AluMisc result
am_wb_ready  out  1  AluMisc queue can accept
mem_wb_valid / mem_wb_regdest / mem_wb_writereg / mem_wb_data / mem_wb_ready  same widths and directions  Mem unit
mul_wb_valid / mul_wb_regdest / mul_wb_writereg / mul_wb_data / mul_wb_ready  same widths and directions  Mult unit
wb_reg_writeaddr  out  5  ARF write address
wb_reg_writedata  out  DATA_W  ARF write data
wb_reg_writeenable  out  1  ARF write strobe
wb_sb_writeaddr  out  5  scoreboard row to release
wb_sb_registerunit  out  2  unit code of the completing unit
wb_sb_enablewrite  out  1  scoreboard release strobe

Behaviour:
- Reset: clock is single-domain; reset is asynchronous, active-low. While reset is low:
  - all queues empty;
  - all write outputs, addresses, data and registerunit are 0;
  - round-robin pointer = AM.
- Reset asserted mid-operation discards all queued results. No partial write is emitted.
- Handshake:
  - A unit result is accepted on a rising edge with x_wb_valid=1 and x_wb_ready=1.
  - x_wb_ready = (queue count < DEPTH). It is decoded from the registered count only, with no combinational path from valid.
  - Valid while ready=0 is ignored. The unit must hold the result.
- Filtering: results with writereg=0 or regdest=0 are accepted (ready still obeyed) but never enqueued. They produce no ARF or scoreboard write.
- Queues:
  - One FIFO per unit with registered count.
  - Wrap-around pointers modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Ready=0 when full, so push-on-full cannot occur.
- Arbitration:
  - Each cycle, among non-empty queues, grant one in round-robin order AM→MEM→MUL, starting after the last granted unit.
  - Granted queue pops its head on that edge. The pointer moves to the granted unit.
  - Ordering is in order within a unit; out of order across units is permitted, since issue guarantees no WAW between units.
- Latency:
  - A result accepted at edge N is in the queue after N.
  - Earliest grant is the cycle after N, with outputs registered at edge N+1.
  - Minimum valid-to-write latency is 2 edges. There is no bypass from input to output.
- Outputs:
  - On a grant edge: wb_reg_writeaddr = wb_sb_writeaddr = regdest, wb_reg_writedata = data, wb_sb_registerunit = unit code, and both strobes = 1.
  - With no grant: both strobes = 0, and address/data/unit hold their last values.
  - The two strobes are always identical.
- Throughput: exactly one write per cycle while any queue is non-empty. A unit stalls only when its own queue is full.

Decomposition:
- Shared package (wb_pkg): unit codes UNIT_AM=2'b00, UNIT_MEM=2'b01, UNIT_MUL=2'b10, UNIT_NONE=2'b11, matching issue's functional-unit encoding; default DEPTH.
- One sub-module: wb_queue (parameterised FIFO of {regdest, data}, push/pop/count/full/empty), instantiated three times.
- Arbiter and output registers live in writeback_arbiter.

Test Plan:
1. Reset low mid-stream with 2 entries queued in AM → strobes 0 immediately and all outputs 0; after release, no stale write appears.
2. Single AM result at edge N (regdest=5, data=0xDEADBEEF) → at edge N+2, writeaddr=5, writedata=0xDEADBEEF, registerunit=00, both strobes high for 1 cycle.
3. AM, MEM, MUL all valid in the same cycle (regdest 1/2/3) → writes on 3 consecutive cycles in order 1,2,3 with registerunit 00,01,10; all readies stay high.
4. MUL sends DEPTH+1 back-to-back results while AM and MEM are continuously busy → mul_wb_ready drops when its queue is full; the third result is held and accepted after a pop; no result is lost or duplicated; MUL order is preserved.
5. MEM result with writereg=0 (store) and AM result with regdest=0 → both accepted, no strobe generated.
6. Continuous traffic on all units for 300 cycles → grant counts per unit differ by ≤1; exactly one strobe every cycle once the queues are primed.
